// File: rtl/store_narrow_unit_pkg.sv
// Shared definitions for the store narrowing unit: size encodings, FSM states,
// lane geometry and the alignment rule used by both the unit and its merger.
package store_narrow_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MRG,
    WR,
    ERR
  } state_e;

  // A request is rejected if its size is reserved or its address is not
  // naturally aligned to that size.
  function automatic logic is_bad_request(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_narrow_unit_if.sv
// Request and data-memory signals of the store narrowing unit.
// master = store control / memory side, slave = the unit itself.
interface store_narrow_unit_if #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 30
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [31:0]       req_wdata;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              err;
  logic              ovf;

  modport master (
    output req_valid, req_addr, req_size, req_wdata, mem_rdata,
    input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err, ovf
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_wdata, mem_rdata,
    output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err, ovf
  );
endinterface

// File: rtl/store_narrow_unit_lane_merge.sv
// Combinational little-endian lane merge: drops the low byte/halfword of wdata
// into the addressed lane of the old memory word; a word replaces everything.
module store_lane_merge
  import store_narrow_unit_pkg::*;
(
  input  logic [WORD_W-1:0] old_word_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [1:0]        size_i,
  input  logic [1:0]        addr_lo_i,
  output logic [WORD_W-1:0] merged_o
);

  always_comb begin
    // NOTE: default the output before the case so no path leaves it unassigned (no latch).
    merged_o = old_word_i;
    case (size_i)
      SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: BYTE_W]    = wdata_i[BYTE_W-1:0];
      SZ_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: HALF_W] = wdata_i[HALF_W-1:0];
      SZ_WORD: merged_o = wdata_i;
      default: merged_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: byte/half stores via read-modify-write, word stores direct.
// Optional narrowing-overflow flag enabled by defining STORE_NARROW_OVF_EN.
module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 30  // must equal ADDR_W-2
) (
  input  logic             clk,
  input  logic             rst_n,
  store_narrow_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;

  logic        accept;
  logic        ready_c, rd_en_c, wr_en_c, done_c, err_c;
  logic [31:0] wdata_c;
  logic [31:0] merged;

  assign accept = (state_q == IDLE) && bus.req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        size_q  <= bus.req_size;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  store_lane_merge u_merge (
    .old_word_i (bus.mem_rdata),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .merged_o   (merged)
  );

  // Strobes come straight from the state, so an async reset clears them at once.
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    rd_en_c = 1'b0;
    wr_en_c = 1'b0;
    done_c  = 1'b0;
    err_c   = 1'b0;
    wdata_c = '0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid) begin
          if (is_bad_request(bus.req_size, bus.req_addr[1:0])) state_d = ERR;
          else if (bus.req_size == SZ_WORD)                    state_d = WR;
          else                                                 state_d = RD;
        end
      end
      RD: begin
        rd_en_c = 1'b1;
        state_d = MRG;
      end
      MRG: begin
        wr_en_c = 1'b1;
        done_c  = 1'b1;
        wdata_c = merged;
        state_d = IDLE;
      end
      WR: begin
        wr_en_c = 1'b1;
        done_c  = 1'b1;
        wdata_c = wdata_q;
        state_d = IDLE;
      end
      ERR: begin
        err_c   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = ready_c;
  assign bus.mem_rd_en = rd_en_c;
  assign bus.mem_wr_en = wr_en_c;
  assign bus.mem_wdata = wdata_c;
  assign bus.mem_addr  = addr_q[ADDR_W-1:2];
  assign bus.done      = done_c;
  assign bus.err       = err_c;

`ifdef STORE_NARROW_OVF_EN
  // Overflow when the discarded upper bits are neither a zero- nor a sign-extension.
  logic [23:0] hi_byte;
  logic [15:0] hi_half;
  logic        ovf_c;

  assign hi_byte = wdata_q[31:8];
  assign hi_half = wdata_q[31:16];

  always_comb begin
    ovf_c = 1'b0;
    case (size_q)
      SZ_BYTE: ovf_c = (hi_byte != '0) && (hi_byte != {24{wdata_q[7]}});
      SZ_HALF: ovf_c = (hi_half != '0) && (hi_half != {16{wdata_q[15]}});
      default: ovf_c = 1'b0;
    endcase
  end

  assign bus.ovf = done_c & ovf_c;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit: directed vector table, reset-in-RD
// sequence and random stores against a byte-mask reference model and memory.
module tb_store_narrow_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  store_narrow_unit_if #(.ADDR_W(32), .MEM_AW(30)) bus ();

  store_narrow_unit #(.ADDR_W(32), .MEM_AW(30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: strobes sampled mid-cycle, acted on at the next edge,
  // so read data appears the cycle after the read strobe.
  logic [31:0] tb_mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] mem_rdata_q;
  logic        rd_s, wr_s, pre_we;
  logic [7:0]  addr_s, pre_idx;
  logic [31:0] wdata_s, pre_val;

  initial begin
    mem_rdata_q = '0;
    rd_s = 1'b0; wr_s = 1'b0; addr_s = '0; wdata_s = '0;
  end

  assign bus.mem_rdata = mem_rdata_q;

  always @(negedge clk) begin
    rd_s    = bus.mem_rd_en;
    wr_s    = bus.mem_wr_en;
    addr_s  = bus.mem_addr[7:0];
    wdata_s = bus.mem_wdata;
  end

  always @(posedge clk) begin
    if (pre_we) tb_mem[pre_idx] = pre_val;
    if (rd_s)   mem_rdata_q = tb_mem[addr_s];
    if (wr_s)   tb_mem[addr_s] = wdata_s;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pre_idx = idx; pre_val = val; pre_we = 1'b1;
    ref_mem[idx] = val;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Reference model: plain mask/shift arithmetic and numeric ranges.
  function automatic logic model_err(input logic [31:0] addr, input logic [1:0] size);
    return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [31:0] addr);
    int unsigned sh;
    logic [31:0] mask;
    if (model_err(addr, size)) return old;
    if (size == 2'd2) return wd;
    if (size == 2'd0) begin
      sh = 8 * (addr % 4);
      mask = 32'h0000_00FF << sh;
      return (old & ~mask) | ((wd & 32'h0000_00FF) << sh);
    end
    sh = 16 * ((addr % 4) / 2);
    mask = 32'h0000_FFFF << sh;
    return (old & ~mask) | ((wd & 32'h0000_FFFF) << sh);
  endfunction

  function automatic logic model_ovf(input logic [31:0] wd, input logic [1:0] size);
`ifdef STORE_NARROW_OVF_EN
    if (size == 2'd0) return !(wd <= 32'h0000_00FF || wd >= 32'hFFFF_FF80);
    if (size == 2'd1) return !(wd <= 32'h0000_FFFF || wd >= 32'hFFFF_8000);
    return 1'b0;
`else
    return 1'b0 & wd[0] & size[0];
`endif
  endfunction

  // Issues one request from IDLE (called at posedge+1) and checks every cycle
  // until the unit is back in IDLE, then checks the memory word.
  task automatic run_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wd, input logic exp_err,
                           input logic [31:0] exp_word, input logic exp_ovf);
    logic [7:0] idx;
    idx = addr[9:2];
    check({tag, " ready@T"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_size = size; bus.req_wdata = wd;
    @(posedge clk); #1;
    // Inputs must be ignored while busy.
    bus.req_valid = 1'($urandom_range(0, 1));
    bus.req_addr  = $urandom;
    bus.req_size  = 2'($urandom_range(0, 3));
    bus.req_wdata = $urandom;
    check({tag, " ready@T+1"}, {31'd0, bus.req_ready}, 32'd0);
    if (exp_err) begin
      check({tag, " err@T+1"},  {31'd0, bus.err},       32'd1);
      check({tag, " rd@T+1"},   {31'd0, bus.mem_rd_en}, 32'd0);
      check({tag, " wr@T+1"},   {31'd0, bus.mem_wr_en}, 32'd0);
      check({tag, " done@T+1"}, {31'd0, bus.done},      32'd0);
    end else if (size == 2'd2) begin
      check({tag, " wr@T+1"},    {31'd0, bus.mem_wr_en}, 32'd1);
      check({tag, " done@T+1"},  {31'd0, bus.done},      32'd1);
      check({tag, " rd@T+1"},    {31'd0, bus.mem_rd_en}, 32'd0);
      check({tag, " err@T+1"},   {31'd0, bus.err},       32'd0);
      check({tag, " addr@T+1"},  {2'b00, bus.mem_addr},  addr >> 2);
      check({tag, " wdata@T+1"}, bus.mem_wdata,          wd);
      check({tag, " ovf@T+1"},   {31'd0, bus.ovf},       32'd0);
    end else begin
      check({tag, " rd@T+1"},   {31'd0, bus.mem_rd_en}, 32'd1);
      check({tag, " wr@T+1"},   {31'd0, bus.mem_wr_en}, 32'd0);
      check({tag, " done@T+1"}, {31'd0, bus.done},      32'd0);
      check({tag, " addr@T+1"}, {2'b00, bus.mem_addr},  addr >> 2);
      @(posedge clk); #1;
      check({tag, " ready@T+2"}, {31'd0, bus.req_ready}, 32'd0);
      check({tag, " wr@T+2"},    {31'd0, bus.mem_wr_en}, 32'd1);
      check({tag, " done@T+2"},  {31'd0, bus.done},      32'd1);
      check({tag, " rd@T+2"},    {31'd0, bus.mem_rd_en}, 32'd0);
      check({tag, " err@T+2"},   {31'd0, bus.err},       32'd0);
      check({tag, " wdata@T+2"}, bus.mem_wdata,          exp_word);
      check({tag, " ovf@T+2"},   {31'd0, bus.ovf},       {31'd0, exp_ovf});
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check({tag, " ready@end"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, " strobes@end"}, {28'd0, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err}, 32'd0);
    check({tag, " addr hold"}, {2'b00, bus.mem_addr}, addr >> 2);
    check({tag, " mem word"},  tb_mem[idx], exp_word);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] old_word;
    logic        exp_err;
    logic [31:0] exp_word;
    logic        exp_ovf_en;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] a, wd, ew;
    logic [1:0]  sz;
    logic        ee, eo;
    int          pick;

    n_checks = 0;
    n_errors = 0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_size = '0; bus.req_wdata = '0;

    vecs[0]  = '{"byte 0x41",   32'h41, 2'b00, 32'h0000_00AB, 32'h1122_3344, 1'b0, 32'h1122_AB44, 1'b0};
    vecs[1]  = '{"half 0x42",   32'h42, 2'b01, 32'h0000_BEEF, 32'h1122_3344, 1'b0, 32'hBEEF_3344, 1'b0};
    vecs[2]  = '{"word 0x40",   32'h40, 2'b10, 32'hDEAD_BEEF, 32'h1122_3344, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{"half 0x43",   32'h43, 2'b01, 32'h0000_BEEF, 32'h1122_3344, 1'b1, 32'h1122_3344, 1'b0};
    vecs[4]  = '{"word 0x42",   32'h42, 2'b10, 32'hDEAD_BEEF, 32'h1122_3344, 1'b1, 32'h1122_3344, 1'b0};
    vecs[5]  = '{"rsvd 0x40",   32'h40, 2'b11, 32'hCAFE_F00D, 32'h1122_3344, 1'b1, 32'h1122_3344, 1'b0};
    vecs[6]  = '{"ovf h12345",  32'h40, 2'b01, 32'h0001_2345, 32'h1122_3344, 1'b0, 32'h1122_2345, 1'b1};
    vecs[7]  = '{"ovf hFFFF8k", 32'h42, 2'b01, 32'hFFFF_8000, 32'h1122_3344, 1'b0, 32'h8000_3344, 1'b0};
    vecs[8]  = '{"ovf h8000",   32'h40, 2'b01, 32'h0000_8000, 32'h1122_3344, 1'b0, 32'h1122_8000, 1'b0};
    vecs[9]  = '{"byte sext",   32'h43, 2'b00, 32'hFFFF_FF80, 32'h1122_3344, 1'b0, 32'h8022_3344, 1'b0};
    vecs[10] = '{"byte ovf",    32'h40, 2'b00, 32'h0000_0180, 32'h1122_3344, 1'b0, 32'h1122_3380, 1'b1};

    // Reset state.
    rst_n = 1'b0;
    #2;
    check("reset ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset strobes", {27'd0, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err, bus.ovf}, 32'd0);
    check("reset mem_addr", {2'b00, bus.mem_addr}, 32'd0);
    check("reset mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) preload(8'(8'h10 + i), $urandom);

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      preload(8'h10, vecs[i].old_word);
`ifdef STORE_NARROW_OVF_EN
      eo = vecs[i].exp_ovf_en;
`else
      eo = 1'b0;
`endif
      run_store(vecs[i].name, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                vecs[i].exp_err, vecs[i].exp_word, eo);
      ref_mem[8'h10] = vecs[i].exp_word;
    end

    // Reset during the RD cycle of a byte store.
    preload(8'h10, 32'h1122_3344);
    bus.req_valid = 1'b1; bus.req_addr = 32'h41; bus.req_size = 2'b00; bus.req_wdata = 32'h0000_00AB;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rst-mid rd", {31'd0, bus.mem_rd_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst-mid ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst-mid strobes", {28'd0, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err}, 32'd0);
    check("rst-mid mem_addr", {2'b00, bus.mem_addr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("rst-mid no write", {30'd0, bus.mem_wr_en, bus.done}, 32'd0);
      @(posedge clk); #1;
    end
    check("rst-mid mem word", tb_mem[8'h10], 32'h1122_3344);

    // Random stores against the reference model.
    for (int i = 0; i < 60; i++) begin
      a    = ($urandom & 32'hFFFF_FC3F) | 32'h0000_0040;
      pick = $urandom_range(0, 7);
      sz   = (pick == 7) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       wd = $urandom;
        1:       wd = $urandom_range(0, 255);
        2:       wd = 32'hFFFF_FF00 | $urandom_range(0, 255);
        default: wd = $urandom & 32'h0001_FFFF;
      endcase
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a = a & ~32'h1;
        if (sz == 2'b10) a = a & ~32'h3;
      end
      ee = model_err(a, sz);
      ew = model_word(ref_mem[a[9:2]], wd, sz, a);
      eo = ee ? 1'b0 : model_ovf(wd, sz);
      run_store($sformatf("rand%0d", i), a, sz, wd, ee, ew, eo);
      ref_mem[a[9:2]] = ew;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-side counterpart of the load-path sign extender.
- Takes a 32-bit register value and writes only its low byte, halfword or full word into a word-addressed data memory.
- Byte and halfword stores use a read-modify-write sequence; word stores write directly.
- Sits between the MEM-stage store control and the data memory.

Parameters:
- ADDR_W, 32, byte-address width of the request.
- MEM_AW, 30, word-address width to memory; must equal ADDR_W-2.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_addr  input  ADDR_W  byte address.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error).
- req_wdata  input  32  source register value; low bits are stored.
- mem_addr  output  MEM_AW  word address, equal to req_addr[ADDR_W-1:2].
- mem_rd_en  output  1  read strobe; read data is valid the next cycle.
- mem_rdata  input  32  read data.
- mem_wr_en  output  1  write strobe.
- mem_wdata  output  32  merged write word.
- done  output  1  one-cycle pulse when the store completes.
- err  output  1  one-cycle pulse on a misaligned or reserved request.
- ovf  output  1  narrowing overflow flag, valid with done (see Optional Feature).

Behaviour:
- Reset state: state=IDLE, req_ready=1, mem_rd_en=0, mem_wr_en=0, done=0, err=0, ovf=0, mem_addr=0, mem_wdata=0.
- Accept: a request is accepted when req_valid & req_ready in IDLE. On accept, latch addr, size and wdata into registers. Inputs are ignored in every other state.
- States:
  - IDLE: on accept, byte/half → RD; word → WR; misaligned or reserved → ERR.
  - RD: mem_rd_en=1, mem_addr=latched word address. Next state → MRG.
  - MRG: capture mem_rdata, replace the selected lane(s), drive mem_wr_en=1 with the merged word, done=1. Next state → IDLE.
  - WR: mem_wr_en=1, mem_wdata=latched wdata, done=1. Next state → IDLE.
  - ERR: err=1, no memory strobes. Next state → IDLE.
- Lane mapping is little-endian:
  - Byte at addr[1:0]=k replaces bits [8k+7:8k] with wdata[7:0].
  - Halfword at addr[1]=h replaces bits [16h+15:16h] with wdata[15:0].
- Alignment: a halfword with addr[0]=1, a word with addr[1:0]≠0, or size=11 is an error. No memory access occurs.
- Latency from the accept edge T:
  - byte/half: read at T+1, write+done at T+2.
  - word: write+done at T+1.
  - error: err at T+1.
  - Throughput is one request per 3 cycles (byte/half) or per 2 cycles (word, error).
- Strobes: mem_rd_en and mem_wr_en are never high in the same cycle. done and err are never high in the same cycle.
- Reset mid-operation: Rst_n low forces IDLE and clears all outputs immediately. A pending write is dropped and no done is issued.
- mem_addr holds its latched value after completion until the next accept.

Optional Feature:
- Macro: STORE_NARROW_OVF_EN.
- Defined: in the done cycle, ovf=1 iff the bits above the stored width are neither all zero nor all equal to the stored value's sign bit.
  - For a byte store, check wdata[31:8] against 0 and against {24{wdata[7]}}.
  - For a halfword store, check wdata[31:16] likewise.
  - Word stores always give ovf=0.
  - The store still completes normally.
- Undefined: ovf is tied to 0 and the check logic is absent.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state enum {IDLE, RD, MRG, WR, ERR};
  - the lane-select helper constants.
- Natural sub-module: store_lane_merge, combinational. Inputs: old word, wdata, size, addr[1:0]. Output: merged word. It can be unit-tested alone.

Test Plan:
- Byte merge: memory[0x10]=0x11223344; store byte wdata=0x000000AB to addr 0x41 → mem_rd_en at T+1 with mem_addr=0x10; mem_wr_en+done at T+2 with mem_wdata=0x1122AB44.
- Halfword merge: same memory, wdata=0x0000BEEF, addr 0x42 → mem_wdata=0xBEEF3344 at T+2; req_ready low during T+1 and T+2.
- Word direct: wdata=0xDEADBEEF, addr 0x40 → no read; mem_wr_en+done at T+1 with mem_wdata=0xDEADBEEF.
- Misaligned: halfword to 0x43, and word to 0x42 → err pulse at T+1; mem_rd_en and mem_wr_en stay 0; back in IDLE at T+2.
- Overflow (macro defined), all halfword stores:
  - wdata=0x00012345 → ovf=1 with done;
  - wdata=0xFFFF8000 → ovf=0;
  - wdata=0x00008000 → ovf=0.
  - With the macro undefined, ovf=0 in all three cases.
- Reset mid-op: assert Rst_n=0 during the RD cycle of a byte store → no mem_wr_en or done follows; req_ready=1 immediately; memory unchanged.
